// File: rtl/bip_pkg.sv
// Shared constants and types for the BIP halt-report framer.
// Optional feature macro: BIP_REPORT_CHECKSUM_EN (appends an XOR checksum byte).
package bip_pkg;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_SEND = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [4:0] HALT_OPCODE = 5'b00000;
    localparam logic [7:0] HEADER_BYTE = 8'hA5;
    localparam int         FIXED_BYTES = 5;  // header, PC hi/lo, ACC hi/lo

`ifdef BIP_REPORT_CHECKSUM_EN
    localparam int CHECKSUM_BYTES = 1;
`else
    localparam int CHECKSUM_BYTES = 0;
`endif

    function automatic int frame_len(input int nb_cycle);
        return FIXED_BYTES + nb_cycle / 8 + CHECKSUM_BYTES;
    endfunction

endpackage

// File: rtl/bip_report_serializer.sv
// Walks the report frame one byte per handshake; byte index, byte mux and the
// optional checksum (BIP_REPORT_CHECKSUM_EN) live here.
module bip_report_serializer
    import bip_pkg::*;
#(
    parameter int NB_CYCLE = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                active,
    input  logic                ready,
    input  logic [15:0]         pc,
    input  logic [15:0]         acc,
    input  logic [NB_CYCLE-1:0] count,
    output logic [7:0]          tx_data,
    output logic                tx_valid,
    output logic                last_accept
);

    localparam int N_CNT_BYTES = NB_CYCLE / 8;
    localparam int FRAME_LEN   = frame_len(NB_CYCLE);
    localparam int IDX_W       = $clog2(FRAME_LEN);

    logic [IDX_W-1:0] idx;
    logic [7:0]       cur_byte;
    logic             accept;
    logic             is_last;

    assign accept      = active && ready;
    assign is_last     = (idx == IDX_W'(FRAME_LEN - 1));
    assign last_accept = accept && is_last;
    assign tx_valid    = active;
    assign tx_data     = active ? cur_byte : 8'h00;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx <= '0;
        end else if (accept && !is_last) begin
            idx <= idx + IDX_W'(1);
        end
    end

`ifdef BIP_REPORT_CHECKSUM_EN
    logic [7:0] checksum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            checksum <= 8'h00;
        end else if (accept) begin
            checksum <= checksum ^ cur_byte;
        end
    end
`endif

    // NOTE: cur_byte gets a default first so no path through this block infers a latch.
    always_comb begin
        cur_byte = 8'h00;
        case (int'(idx))
            0:       cur_byte = HEADER_BYTE;
            1:       cur_byte = pc[15:8];
            2:       cur_byte = pc[7:0];
            3:       cur_byte = acc[15:8];
            4:       cur_byte = acc[7:0];
            default: begin
                for (int k = 0; k < N_CNT_BYTES; k++) begin
                    if (int'(idx) == FIXED_BYTES + k) cur_byte = count[NB_CYCLE-1-8*k -: 8];
                end
`ifdef BIP_REPORT_CHECKSUM_EN
                if (is_last) cur_byte = checksum;
`endif
            end
        endcase
    end

endmodule

// File: rtl/bip_report_framer.sv
// Counts processor steps until HALT, then freezes the processor and sends a
// PC/ACC/cycle-count report frame. Optional checksum byte: BIP_REPORT_CHECKSUM_EN.
module bip_report_framer
    import bip_pkg::*;
#(
    parameter int NB_DATA            = 16,
    parameter int NB_OPCODE          = 5,
    parameter int LOG2_N_INSMEM_ADDR = 11,
    parameter int NB_CYCLE           = 32
) (
    input  logic                          i_clock,
    input  logic                          i_reset,
    input  logic                          i_valid,
    input  logic [NB_DATA-1:0]            i_instruction,
    input  logic [LOG2_N_INSMEM_ADDR-1:0] i_pc,
    input  logic [NB_DATA-1:0]            i_acc,
    output logic                          o_bip_valid,
    output logic [7:0]                    o_tx_data,
    output logic                          o_tx_valid,
    input  logic                          i_tx_ready,
    output logic                          o_done
);

    state_t                state, state_next;
    logic [NB_CYCLE-1:0]   cycle_count, count_inc, snap_count;
    logic [15:0]           snap_pc, snap_acc;
    logic [NB_OPCODE-1:0]  opcode;
    logic                  halt, sending, last_accept;
    logic                  unused_operand;

    assign opcode         = i_instruction[NB_DATA-1 -: NB_OPCODE];
    assign unused_operand = ^i_instruction[NB_DATA-NB_OPCODE-1:0];
    assign count_inc      = (&cycle_count) ? cycle_count : cycle_count + NB_CYCLE'(1);
    assign halt           = (state == ST_RUN) && i_valid && (opcode == NB_OPCODE'(HALT_OPCODE));
    assign sending        = (state == ST_SEND);

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) state <= ST_RUN;
        else          state <= state_next;
    end

    // The HALT cycle still counts, so the snapshot takes the incremented value.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            cycle_count <= '0;
            snap_count  <= '0;
            snap_pc     <= '0;
            snap_acc    <= '0;
        end else begin
            if ((state == ST_RUN) && i_valid) cycle_count <= count_inc;
            if (halt) begin
                snap_count <= count_inc;
                snap_pc    <= 16'(i_pc);
                snap_acc   <= 16'(i_acc);
            end
        end
    end

    always_comb begin
        state_next  = state;
        o_bip_valid = 1'b0;
        o_done      = 1'b0;
        case (state)
            ST_RUN: begin
                o_bip_valid = i_valid;
                if (halt) state_next = ST_SEND;
            end
            ST_SEND: begin
                if (last_accept) state_next = ST_DONE;
            end
            ST_DONE: begin
                o_done = 1'b1;
            end
            default: state_next = ST_RUN;
        endcase
    end

    bip_report_serializer #(
        .NB_CYCLE(NB_CYCLE)
    ) u_serializer (
        .clk        (i_clock),
        .rst_n      (i_reset),
        .active     (sending),
        .ready      (i_tx_ready),
        .pc         (snap_pc),
        .acc        (snap_acc),
        .count      (snap_count),
        .tx_data    (o_tx_data),
        .tx_valid   (o_tx_valid),
        .last_accept(last_accept)
    );

endmodule

// File: tb/tb_bip_report_framer.sv
// Scoreboard bench for bip_report_framer: directed halt scenarios push expected
// frame bytes; a negedge monitor pops and compares on every handshake.
module tb_bip_report_framer;

    logic        i_clock = 1'b0;
    logic        i_reset = 1'b0;
    logic        i_valid = 1'b0;
    logic [15:0] i_instruction = 16'h0000;
    logic [10:0] i_pc = 11'h000;
    logic [15:0] i_acc = 16'h0000;
    logic        i_tx_ready = 1'b1;
    logic        o_bip_valid;
    logic [7:0]  o_tx_data;
    logic        o_tx_valid;
    logic        o_done;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [7:0]  exp_q[$];
    int          byte_count = 0;
    bit          ready_pattern_en = 1'b0;
    logic [3:0]  ready_pat = 4'b1001;
    int          ready_ph = 0;
    logic        prev_stall = 1'b0;
    logic [7:0]  prev_data = 8'h00;

    bip_report_framer dut (
        .i_clock      (i_clock),
        .i_reset      (i_reset),
        .i_valid      (i_valid),
        .i_instruction(i_instruction),
        .i_pc         (i_pc),
        .i_acc        (i_acc),
        .o_bip_valid  (o_bip_valid),
        .o_tx_data    (o_tx_data),
        .o_tx_valid   (o_tx_valid),
        .i_tx_ready   (i_tx_ready),
        .o_done       (o_done)
    );

    always #5 i_clock = ~i_clock;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Ready source: constant 1, or the repeating 1-0-0-1 pattern.
    initial begin
        forever begin
            @(posedge i_clock);
            #1;
            if (ready_pattern_en) begin
                i_tx_ready = ready_pat[3 - ready_ph];
                ready_ph   = (ready_ph + 1) % 4;
            end else begin
                i_tx_ready = 1'b1;
            end
        end
    end

    // Monitor: pops one expected byte per handshake, checks hold-while-stalled and idle zero.
    always @(negedge i_clock) begin
        if (o_tx_valid) begin
            if (prev_stall) check("tx_data_stable", 32'(o_tx_data), 32'(prev_data));
            if (i_tx_ready) begin
                byte_count++;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_byte: got 0x%0h, expected no byte", o_tx_data);
                end else begin
                    check("frame_byte", 32'(o_tx_data), 32'(exp_q.pop_front()));
                end
            end
            prev_stall = !i_tx_ready;
            prev_data  = o_tx_data;
        end else begin
            check("idle_data_zero", 32'(o_tx_data), 32'h0);
            prev_stall = 1'b0;
        end
    end

    task automatic push_frame(input logic [15:0] pc, input logic [15:0] acc, input logic [31:0] cnt);
        logic [7:0] frame [9];
        logic [7:0] x;
        frame = '{8'hA5, pc[15:8], pc[7:0], acc[15:8], acc[7:0],
                  cnt[31:24], cnt[23:16], cnt[15:8], cnt[7:0]};
        x = 8'h00;
        for (int i = 0; i < 9; i++) begin
            exp_q.push_back(frame[i]);
            x ^= frame[i];
        end
`ifdef BIP_REPORT_CHECKSUM_EN
        exp_q.push_back(x);
`endif
    endtask

    // One RUN-phase processor cycle; o_bip_valid must mirror i_valid before the edge.
    task automatic step(input logic v, input logic [15:0] ins, input logic [10:0] pc, input logic [15:0] acc);
        i_valid       = v;
        i_instruction = ins;
        i_pc          = pc;
        i_acc         = acc;
        #1;
        check("bip_valid_run", 32'(o_bip_valid), 32'(v));
        @(posedge i_clock);
        #1;
    endtask

    task automatic do_reset();
        i_reset          = 1'b0;
        i_valid          = 1'b1;
        i_instruction    = 16'h0800;
        ready_pattern_en = 1'b0;
        exp_q.delete();
        byte_count = 0;
        repeat (2) @(posedge i_clock);
        #1;
        check("rst_tx_valid", 32'(o_tx_valid), 32'h0);
        check("rst_tx_data", 32'(o_tx_data), 32'h0);
        check("rst_done", 32'(o_done), 32'h0);
        check("rst_bip_valid_run", 32'(o_bip_valid), 32'h1);
        i_valid = 1'b0;
        i_reset = 1'b1;
        @(posedge i_clock);
        #1;
    endtask

    task automatic wait_done(input string name, input int budget);
        int n = 0;
        while (!o_done && n < budget) begin
            @(posedge i_clock);
            #1;
            n++;
        end
        check({name, "_done"}, 32'(o_done), 32'h1);
        check({name, "_queue_empty"}, 32'(exp_q.size()), 32'h0);
        check({name, "_tx_valid_low"}, 32'(o_tx_valid), 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog");
    end

    initial begin
        // Basic report: 5 counted cycles + HALT -> count 6.
        do_reset();
        for (int k = 0; k < 5; k++) step(1'b1, 16'((k + 1) << 11), 11'(k), 16'(k));
        push_frame(16'h0005, 16'h1234, 32'd6);
        step(1'b1, 16'h0000, 11'h005, 16'h1234);
        check("halt_latency_valid", 32'(o_tx_valid), 32'h1);
        check("halt_latency_header", 32'(o_tx_data), 32'hA5);
        check("send_bip_valid_gated", 32'(o_bip_valid), 32'h0);
        i_pc          = 11'h7AA;
        i_acc         = 16'hDEAD;
        i_instruction = 16'h0000;
        wait_done("basic", 40);

        // Back-pressure plus invalid cycles carrying the HALT opcode.
        do_reset();
        ready_pattern_en = 1'b1;
        ready_ph         = 0;
        step(1'b1, 16'h1000, 11'h001, 16'h0001);
        step(1'b0, 16'h0000, 11'h3FF, 16'hFFFF);
        check("halt_ignored_invalid_a", 32'(o_tx_valid), 32'h0);
        step(1'b0, 16'h2000, 11'h002, 16'h0002);
        step(1'b1, 16'h3000, 11'h003, 16'h0003);
        step(1'b0, 16'h0000, 11'h004, 16'h0004);
        check("halt_ignored_invalid_b", 32'(o_tx_valid), 32'h0);
        step(1'b1, 16'h4000, 11'h005, 16'h0005);
        push_frame(16'h07FF, 16'hBEEF, 32'd4);
        step(1'b1, 16'h0000, 11'h7FF, 16'hBEEF);
        i_valid = 1'b0;
        wait_done("backpressure", 100);
        ready_pattern_en = 1'b0;

        // Reset after the third byte is accepted, then a fresh full frame.
        do_reset();
        step(1'b1, 16'h0800, 11'h000, 16'h0000);
        step(1'b1, 16'h0800, 11'h000, 16'h0000);
        push_frame(16'h00AB, 16'h5555, 32'd3);
        step(1'b1, 16'h0000, 11'h0AB, 16'h5555);
        begin
            int n = 0;
            while (byte_count < 3 && n < 20) begin
                @(posedge i_clock);
                #1;
                n++;
            end
        end
        check("midsend_three_accepted", 32'(byte_count), 32'd3);
        i_reset = 1'b0;
        #1;
        check("midsend_rst_tx_valid", 32'(o_tx_valid), 32'h0);
        check("midsend_rst_tx_data", 32'(o_tx_data), 32'h0);
        check("midsend_rst_done", 32'(o_done), 32'h0);
        do_reset();
        step(1'b1, 16'h0800, 11'h000, 16'h0000);
        push_frame(16'h0100, 16'hCAFE, 32'd2);
        step(1'b1, 16'h0000, 11'h100, 16'hCAFE);
        i_valid = 1'b0;
        wait_done("fresh_frame", 40);

        // Counter saturation from a preloaded value near all-ones.
        do_reset();
        step(1'b0, 16'h0800, 11'h000, 16'h0000);
        force dut.cycle_count = 32'hFFFF_FFFC;
        step(1'b0, 16'h0800, 11'h000, 16'h0000);
        release dut.cycle_count;
        for (int k = 0; k < 4; k++) step(1'b1, 16'h0800, 11'h000, 16'h0000);
        push_frame(16'h0010, 16'h0001, 32'hFFFF_FFFF);
        step(1'b1, 16'h0000, 11'h010, 16'h0001);
        i_valid = 1'b0;
        wait_done("saturate", 40);

        // DONE is sticky: processor stays frozen and nothing is transmitted.
        i_valid = 1'b1;
        for (int k = 0; k < 100; k++) begin
            i_instruction = 16'((k % 3) << 11);
            @(posedge i_clock);
            #1;
            check("done_bip_valid", 32'(o_bip_valid), 32'h0);
            check("done_tx_valid", 32'(o_tx_valid), 32'h0);
            check("done_sticky", 32'(o_done), 32'h1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
